// File: rtl/get_slice_unpacker_if.sv
// get_slice_unpacker_if: word-in / window-out handshake bundle for the slice unpacker.
interface get_slice_unpacker_if #(
    parameter int WIDTH = 12,
    parameter int SLICE = 6
);
    logic [WIDTH-1:0] I;
    logic [1:0]       x;
    logic [2:0]       step;
    logic             in_valid;
    logic             in_ready;
    logic [SLICE-1:0] O;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [3:0]       idx;

    modport slave (
        input  I, x, step, in_valid, out_ready,
        output in_ready, O, out_valid, out_last, idx
    );

    modport master (
        output I, x, step, in_valid, out_ready,
        input  in_ready, O, out_valid, out_last, idx
    );
endinterface

// File: rtl/get_slice_unpacker.sv
// get_slice_unpacker: streams successive SLICE-bit windows of a latched word, 1-filled past the top.
module get_slice_unpacker #(
    parameter int WIDTH = 12,
    parameter int SLICE = 6,
    parameter int OFFW  = 5
) (
    input logic CLK,
    input logic ASYNCRESET,
    get_slice_unpacker_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state, next;
    logic [WIDTH-1:0]       word;
    logic [OFFW-1:0]        offset;
    logic [2:0]             stride;
    logic [3:0]             beat;
    logic [OFFW-1:0]        sum;
    logic                   last;
    logic [WIDTH+SLICE-1:0] wide;

    assign sum  = offset + OFFW'(stride);
    assign last = sum >= OFFW'(WIDTH);
    // ones above the word supply the fill for windows crossing the top
    assign wide = {{SLICE{1'b1}}, word} >> offset;

    always_ff @(posedge CLK or posedge ASYNCRESET)
        if (ASYNCRESET) state <= IDLE;
        else state <= next;

    always_comb
        next = state == IDLE ? (bus.in_valid ? BUSY : IDLE)
                             : (bus.out_ready && last ? IDLE : BUSY);

    always_ff @(posedge CLK or posedge ASYNCRESET)
        if (ASYNCRESET) begin
            word   <= '0;
            offset <= '0;
            stride <= 3'd1;
            beat   <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            word   <= bus.I;
            offset <= OFFW'(bus.x);
            stride <= bus.step == 3'd0 ? 3'd1 : bus.step;
            beat   <= '0;
        end else if (state == BUSY && bus.out_ready && !last) begin
            offset <= sum;
            beat   <= beat + 4'd1;
        end

    always_comb begin
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == BUSY;
        bus.out_last  = state == BUSY && last;
        bus.O         = state == BUSY ? wide[SLICE-1:0] : '0;
        bus.idx       = beat;
    end
endmodule

// File: tb/tb_get_slice_unpacker.sv
// tb_get_slice_unpacker: directed checks of windowing, fill, stride, backpressure and async reset.
module tb_get_slice_unpacker;
    logic CLK = 1'b0;
    logic ASYNCRESET = 1'b1;
    int   cmp = 0;
    int   errs = 0;

    get_slice_unpacker_if bus ();

    get_slice_unpacker dut (
        .CLK(CLK),
        .ASYNCRESET(ASYNCRESET),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [11:0] i, input logic [1:0] xx, input logic [2:0] st);
        bus.I = i;
        bus.x = xx;
        bus.step = st;
        bus.in_valid = 1'b1;
        chk("send_in_ready", 32'(bus.in_ready), 1);
        @(negedge CLK);
        bus.in_valid = 1'b0;
        bus.I = 12'h5A5;
    endtask

    task automatic beat(input string tag, input logic [5:0] o, input logic [3:0] ix, input logic lst);
        chk({tag, "_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_O"}, 32'(bus.O), 32'(o));
        chk({tag, "_idx"}, 32'(bus.idx), 32'(ix));
        chk({tag, "_last"}, 32'(bus.out_last), 32'(lst));
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        @(negedge CLK);
    endtask

    task automatic idle(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    endtask

    logic [5:0] walk [12] = '{6'h3C, 6'h1E, 6'h2F, 6'h17, 6'h2B, 6'h15,
                              6'h2A, 6'h35, 6'h3A, 6'h3D, 6'h3E, 6'h3F};

    initial begin
        bus.I = '0;
        bus.x = '0;
        bus.step = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge CLK);
        idle("rst");
        chk("rst_O", 32'(bus.O), 0);
        chk("rst_idx", 32'(bus.idx), 0);
        chk("rst_last", 32'(bus.out_last), 0);
        ASYNCRESET = 1'b0;
        @(negedge CLK);
        idle("post_rst");

        send(12'hABC, 2'd0, 3'd6);
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.I = 12'hFFF;
            bus.x = 2'd3;
            beat("stall", 6'h3C, 4'd0, 1'b0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        beat("s1b0", 6'h3C, 4'd0, 1'b0);
        beat("s1b1", 6'h2A, 4'd1, 1'b1);
        idle("s1_done");

        send(12'hABC, 2'd3, 3'd6);
        beat("s2b0", 6'h17, 4'd0, 1'b0);
        beat("s2b1", 6'h3D, 4'd1, 1'b1);
        idle("s2_done");

        send(12'hABC, 2'd0, 3'd0);
        for (int k = 0; k < 12; k++)
            beat($sformatf("s3b%0d", k), walk[k], 4'(k), k == 11);
        idle("s3_done");

        send(12'hABC, 2'd3, 3'd7);
        beat("s4b0", 6'h17, 4'd0, 1'b0);
        beat("s4b1", 6'h3E, 4'd1, 1'b1);
        idle("s4_done");

        send(12'hABC, 2'd0, 3'd6);
        beat("s5b0", 6'h3C, 4'd0, 1'b0);
        #1 ASYNCRESET = 1'b1;
        #1;
        idle("midrst");
        chk("midrst_O", 32'(bus.O), 0);
        chk("midrst_last", 32'(bus.out_last), 0);
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        @(negedge CLK);
        idle("midrst_rel");
        send(12'h000, 2'd0, 3'd6);
        beat("s6b0", 6'h00, 4'd0, 1'b0);
        beat("s6b1", 6'h00, 4'd1, 1'b1);
        idle("s6_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
